// File: rtl/group_carry_lookahead_if.sv
// Handshake bundle between a row of group adders, the carry-lookahead unit
// and whatever consumes the resolved carries.
interface group_carry_lookahead_if #(
  parameter int NGROUPS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*NGROUPS-1:0]   qg_in;
  logic                   cin;
  logic                   out_valid;
  logic                   out_ready;
  logic [NGROUPS-1:0]     c_out;
  logic                   cout;
  logic [1:0]             qg_out;

  modport master (
    output in_valid, qg_in, cin, out_ready,
    input  in_ready, out_valid, c_out, cout, qg_out
  );

  modport slave (
    input  in_valid, qg_in, cin, out_ready,
    output in_ready, out_valid, c_out, cout, qg_out
  );
endinterface

// File: rtl/group_carry_lookahead.sv
// Second-level carry lookahead: resolves per-group carries and a super-group
// generate/propagate pair through a two-stage valid/ready pipeline.
module group_carry_lookahead #(
  parameter int NGROUPS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  group_carry_lookahead_if.slave bus
);

  logic                 a_v;
  logic [2*NGROUPS-1:0] a_qg;
  logic                 a_cin;

  logic                 b_v;
  logic [NGROUPS-1:0]   b_c;
  logic                 b_cout;
  logic [1:0]           b_qg;

  logic                 in_xfer;
  logic                 b_load;

  logic [NGROUPS-1:0]   nxt_c;
  logic                 nxt_cout;
  logic                 sup_g;
  logic                 sup_p;
  logic                 c_run;

  // A full pipeline can still accept when the output drains this same cycle.
  assign bus.in_ready = !a_v || !b_v || bus.out_ready;
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign b_load       = a_v && (!b_v || bus.out_ready);

  always_comb begin
    nxt_c = '0;
    sup_g = 1'b0;
    sup_p = 1'b1;
    c_run = a_cin;
    for (int k = 0; k < NGROUPS; k++) begin
      nxt_c[k] = c_run;
      c_run    = a_qg[2*k+1] | (a_qg[2*k] & c_run);
      sup_g    = a_qg[2*k+1] | (a_qg[2*k] & sup_g);
      sup_p    = sup_p & a_qg[2*k];
    end
    nxt_cout = c_run;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_v    <= 1'b0;
      a_qg   <= '0;
      a_cin  <= 1'b0;
      b_v    <= 1'b0;
      b_c    <= '0;
      b_cout <= 1'b0;
      b_qg   <= 2'b00;
    end else begin
      if (in_xfer) begin
        a_qg  <= bus.qg_in;
        a_cin <= bus.cin;
      end
      if (in_xfer)
        a_v <= 1'b1;
      else if (b_load)
        a_v <= 1'b0;

      if (b_load) begin
        b_c    <= nxt_c;
        b_cout <= nxt_cout;
        b_qg   <= {sup_g, sup_p};
      end
      if (b_load)
        b_v <= 1'b1;
      else if (bus.out_ready)
        b_v <= 1'b0;
    end
  end

  assign bus.out_valid = b_v;
  assign bus.c_out     = b_c;
  assign bus.cout      = b_cout;
  assign bus.qg_out    = b_qg;

endmodule

// File: tb/tb_group_carry_lookahead.sv
// Scoreboard bench for group_carry_lookahead with NGROUPS = 4.
module tb_group_carry_lookahead;
  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] c;
    logic         co;
    logic [1:0]   qg;
  } exp_t;

  logic clk;
  logic rst_n;
  group_carry_lookahead_if #(.NGROUPS(N)) bus ();

  group_carry_lookahead #(.NGROUPS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc_n   = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerrors++;
      $display("FAIL %s got %0h expected %0h", tag, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2*N-1:0] qg, input logic ci);
    exp_t r;
    logic [N:0] c;
    logic gg, pp, term;
    c[0] = ci;
    for (int k = 0; k < N; k++) c[k+1] = qg[2*k+1] | (qg[2*k] & c[k]);
    pp = 1'b1;
    for (int k = 0; k < N; k++) pp = pp & qg[2*k];
    gg = 1'b0;
    for (int j = 0; j < N; j++) begin
      term = qg[2*j+1];
      for (int m = j + 1; m < N; m++) term = term & qg[2*m];
      gg = gg | term;
    end
    r.c  = c[N-1:0];
    r.co = c[N];
    r.qg = {gg, pp};
    return r;
  endfunction

  // One clock cycle: drive after the falling edge, evaluate both handshakes
  // just after, so the following rising edge performs the transfers.
  task automatic cyc(input bit v, input logic [2*N-1:0] qg, input logic c, input bit ordy,
                     input bit has_ex, input exp_t ex, output bit acc, output bit dlv);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.qg_in     = qg;
    bus.cin       = c;
    bus.out_ready = ordy;
    #1;
    cyc_n++;
    acc = v && bus.in_ready;
    dlv = bus.out_valid && ordy;
    if (dlv) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("c_out",  bus.c_out,  e.c);
        chk("cout",   bus.cout,   e.co);
        chk("qg_out", bus.qg_out, e.qg);
      end
    end
    if (acc) sb.push_back(has_ex ? ex : model(qg, c));
  endtask

  task automatic idle(input bit ordy, output bit dlv);
    bit acc;
    cyc(1'b0, '0, 1'b0, ordy, 1'b0, '0, acc, dlv);
  endtask

  task automatic drain(input int budget);
    bit dlv;
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      idle(1'b1, dlv);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, dlv;
    exp_t ex, held;
    int cnt, first, last;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.qg_in     = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    idle(1'b0, dlv);
    idle(1'b0, dlv);
    rst_n = 1'b1;
    idle(1'b1, dlv);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_c_out",     bus.c_out,     0);
    chk("rst_cout",      bus.cout,      0);
    chk("rst_qg_out",    bus.qg_out,    0);
    chk("rst_in_ready",  bus.in_ready,  1);

    // 8'h46, cin=0 with a two-cycle latency check
    ex = '{c: 4'b0110, co: 1'b0, qg: 2'b00};
    cyc(1'b1, 8'h46, 1'b0, 1'b1, 1'b1, ex, acc, dlv);
    chk("acc_46", acc, 1);
    idle(1'b1, dlv);
    chk("lat_not_yet", bus.out_valid, 0);
    idle(1'b1, dlv);
    chk("lat_two", dlv, 1);

    // back-to-back 8'h55 with cin=1 then cin=0
    ex = '{c: 4'b1111, co: 1'b1, qg: 2'b01};
    cyc(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, ex, acc, dlv);
    ex = '{c: 4'b0000, co: 1'b0, qg: 2'b01};
    cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, ex, acc, dlv);
    idle(1'b1, dlv);
    chk("b2b_first", dlv, 1);
    idle(1'b1, dlv);
    chk("b2b_second", dlv, 1);

    ex = '{c: 4'b0000, co: 1'b1, qg: 2'b10};
    cyc(1'b1, 8'h80, 1'b0, 1'b1, 1'b1, ex, acc, dlv);
    drain(6);

    // backpressure: 4 cycles with out_ready low, 3 transactions offered
    cyc(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, '0, acc, dlv);
    chk("stall_acc1", acc, 1);
    cyc(1'b1, 8'hA7, 1'b0, 1'b0, 1'b0, '0, acc, dlv);
    chk("stall_acc2", acc, 1);
    cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, '0, acc, dlv);
    chk("stall_full_acc", acc, 0);
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_out_valid", bus.out_valid, 1);
    held = '{c: bus.c_out, co: bus.cout, qg: bus.qg_out};
    cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, '0, acc, dlv);
    chk("stall_full_acc2", acc, 0);
    chk("stall_hold_c", bus.c_out, held.c);
    chk("stall_hold_co", bus.cout, held.co);
    chk("stall_hold_qg", bus.qg_out, held.qg);
    cyc(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, '0, acc, dlv);
    chk("stall_resume_acc", acc, 1);
    chk("stall_resume_dlv", dlv, 1);
    cnt = 1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      idle(1'b1, dlv);
      if (dlv) cnt++;
    end
    chk("stall_delivered", cnt, 3);

    // full-rate random stream
    cnt = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, '0, acc, dlv);
      chk("stream_acc", acc, 1);
      if (dlv) begin
        cnt++;
        if (first < 0) first = cyc_n;
        last = cyc_n;
      end
    end
    for (int i = 0; i < 6; i++) begin
      idle(1'b1, dlv);
      if (dlv) begin
        cnt++;
        if (first < 0) first = cyc_n;
        last = cyc_n;
      end
    end
    chk("stream_count", cnt, 16);
    chk("stream_span", last - first, 15);

    // reset with two transactions in flight
    cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, '0, acc, dlv);
    cyc(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, '0, acc, dlv);
    idle(1'b0, dlv);
    chk("inflight_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    sb.delete();
    idle(1'b0, dlv);
    rst_n = 1'b1;
    idle(1'b1, dlv);
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_c_out",     bus.c_out,     0);
    chk("mrst_cout",      bus.cout,      0);
    chk("mrst_qg_out",    bus.qg_out,    0);
    chk("mrst_in_ready",  bus.in_ready,  1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1, dlv);
      if (bus.out_valid) cnt++;
    end
    chk("mrst_no_stale", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end
endmodule
